// File: rtl/mem_pkg.sv
// Shared types for the LSU data memory: funct3 encodings, FSM states and the
// load pipeline stage record.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    CLEAR,
    READY
  } mem_state_t;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic        fault;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [31:0] word;
  } mem_pipe_t;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a 32-bit word and sign- or
// zero-extends it according to the load funct3.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    rdata_o = word_i;
      F3_BU:   rdata_o = {24'h000000, byte_sel};
      F3_HU:   rdata_o = {16'h0000, half_sel};
      default: rdata_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_memory_pipelined.sv
// Word-addressed data memory with byte-enable stores, fixed-latency load pipeline
// and a post-reset sequential clear sweep.
module data_memory_pipelined
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned RD_LAT         = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_fault_o,
  output logic        busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  mem_state_t    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          clr_we;

  logic [31:0]   mem_q [DEPTH];
  mem_pipe_t     pipe_q [RD_LAT];
  mem_pipe_t     pipe_in, pipe_out;

  logic          accept, fault, f3_bad, st_we;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   st_data;
  logic [31:0]   aligned;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) state_d = READY;
      end
      READY: begin
        state_d = READY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Gating with reset keeps a store presented during reset from being written.
  assign req_ready_o = !reset && (state_q == READY);
  assign busy_o      = reset ? CLEAR_ON_RESET : (state_q == CLEAR);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    idx = req_addr_i[AW+1:2];
    case (req_funct3_i)
      F3_B:    f3_bad = 1'b0;
      F3_H:    f3_bad = req_addr_i[0];
      F3_W:    f3_bad = |req_addr_i[1:0];
      F3_BU:   f3_bad = req_we_i;
      F3_HU:   f3_bad = req_we_i | req_addr_i[0];
      default: f3_bad = 1'b1;
    endcase
    fault = f3_bad || ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH));

    be      = 4'b0000;
    st_data = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        be[req_addr_i[1:0]] = 1'b1;
        st_data             = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be      = req_addr_i[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata_i[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    st_we = accept && req_we_i && !fault;
  end

  always_ff @(posedge clk) begin
    if (clr_we && !reset) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (st_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    pipe_in.valid  = accept;
    pipe_in.we     = req_we_i;
    pipe_in.fault  = fault;
    pipe_in.funct3 = req_funct3_i;
    pipe_in.lane   = req_addr_i[1:0];
    pipe_in.word   = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pipe_in;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign pipe_out = pipe_q[RD_LAT-1];

  load_align u_load_align (
    .word_i   (pipe_out.word),
    .funct3_i (pipe_out.funct3),
    .lane_i   (pipe_out.lane),
    .rdata_o  (aligned)
  );

  assign rsp_valid_o = pipe_out.valid;
  assign rsp_fault_o = pipe_out.valid && pipe_out.fault;
  assign rsp_rdata_o = (pipe_out.valid && !pipe_out.we && !pipe_out.fault) ? aligned : 32'h0;

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Randomised and directed bench for data_memory_pipelined against a byte-array
// reference model with a timed expected-response queue.
module tb_data_memory_pipelined;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned RD_LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault, busy;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  data_memory_pipelined #(
    .DEPTH          (DEPTH),
    .RD_LAT         (RD_LAT),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_fault_o  (rsp_fault),
    .busy_o       (busy)
  );

  typedef struct {
    int unsigned due;
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [DEPTH*4];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned rsp_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic        last_fault = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour on a little-endian byte array.
  function automatic exp_t model_req(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int unsigned a;
    logic [7:0]  b;
    logic [15:0] h;
    bit          flt;
    a   = addr;
    flt = ((addr >> 2) >= DEPTH) || (f3 == 3) || (f3 == 6) || (f3 == 7) ||
          ((f3 == 1 || f3 == 5) && addr[0]) || (f3 == 2 && addr[1:0] != 2'b00) ||
          (we && (f3 == 4 || f3 == 5));
    e.due   = 0;
    e.fault = flt;
    e.rdata = 32'h0;
    if (!flt) begin
      if (we) begin
        ref_mem[a] = wd[7:0];
        if (f3 != 0) ref_mem[a+1] = wd[15:8];
        if (f3 == 2) begin
          ref_mem[a+2] = wd[23:16];
          ref_mem[a+3] = wd[31:24];
        end
      end else begin
        case (f3)
          3'd0: begin b = ref_mem[a]; e.rdata = {{24{b[7]}}, b}; end
          3'd4: begin b = ref_mem[a]; e.rdata = {24'h0, b}; end
          3'd1: begin h = {ref_mem[a+1], ref_mem[a]}; e.rdata = {{16{h[15]}}, h}; end
          3'd5: begin h = {ref_mem[a+1], ref_mem[a]}; e.rdata = {16'h0, h}; end
          default: e.rdata = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        endcase
      end
    end
    return e;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        exp_q.delete();
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      end else if (req_valid && req_ready) begin
        e     = model_req(req_we, req_funct3, req_addr, req_wdata);
        e.due = cyc + RD_LAT - 1;
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
          check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
          check_eq("rsp_fault", 64'(rsp_fault), 64'(exp_q[0].fault));
          check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].rdata));
          void'(exp_q.pop_front());
        end else begin
          check_eq("idle_rsp", 64'({rsp_valid, rsp_fault, rsp_rdata}), 64'd0);
        end
        if (rsp_valid) begin
          rsp_cnt++;
          last_rdata = rsp_rdata;
          last_fault = rsp_fault;
        end
      end
    end
  end

  task automatic idle_bus();
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int unsigned target);
    for (int i = 0; i < 20 && rsp_cnt < target; i++) @(posedge clk);
    #1;
    check_eq("rsp_seen", 64'(rsp_cnt >= target), 64'd1);
  endtask

  task automatic single(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt);
    int unsigned target;
    target = rsp_cnt + 1;
    drive(we, f3, addr, wd);
    idle_bus();
    wait_rsp(target);
    rd  = last_rdata;
    flt = last_fault;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !req_ready; i++) @(posedge clk);
    #1;
    check_eq("ready_wait", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt;
    int unsigned n;
    int unsigned target;
    int unsigned cnt0;
    logic [2:0]  f3tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  f3;
    logic        we;
    logic [1:0]  lane;
    int unsigned w;

    idle_bus();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_ready", 64'(req_ready), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd1);
    check_eq("reset_rsp", 64'({rsp_valid, rsp_fault, rsp_rdata}), 64'd0);
    reset = 1'b0;

    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy && !req_ready) n++;
      else break;
    end
    check_eq("sweep_len", 64'(n), 64'(DEPTH));
    check_eq("ready_after_sweep", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;

    single(1'b0, 3'd2, 32'h3C, 32'h0, rd, flt);
    check_eq("lw_cleared", 64'(rd), 64'h0);

    single(1'b1, 3'd2, 32'h8, 32'h11223344, rd, flt);
    single(1'b1, 3'd0, 32'hA, 32'h000000AA, rd, flt);
    single(1'b0, 3'd2, 32'h8, 32'h0, rd, flt);
    check_eq("lw_after_sb", 64'(rd), 64'h11AA3344);
    single(1'b0, 3'd0, 32'hA, 32'h0, rd, flt);
    check_eq("lb_signed", 64'(rd), 64'hFFFFFFAA);
    single(1'b0, 3'd4, 32'hA, 32'h0, rd, flt);
    check_eq("lbu", 64'(rd), 64'h000000AA);
    single(1'b0, 3'd1, 32'hA, 32'h0, rd, flt);
    check_eq("lh", 64'(rd), 64'h000011AA);

    target = rsp_cnt + 2;
    drive(1'b1, 3'd2, 32'h4, 32'hDEADBEEF);
    drive(1'b0, 3'd2, 32'h4, 32'h0);
    idle_bus();
    wait_rsp(target);
    check_eq("b2b_load", 64'(last_rdata), 64'hDEADBEEF);

    single(1'b0, 3'd2, 32'h6, 32'h0, rd, flt);
    check_eq("lw_misalign_fault", 64'({flt, rd}), 64'h1_0000_0000);
    single(1'b1, 3'd2, 32'h0, 32'h55667788, rd, flt);
    single(1'b1, 3'd1, 32'h1, 32'h0000BEEF, rd, flt);
    check_eq("sh_misalign_fault", 64'(flt), 64'd1);
    single(1'b0, 3'd2, 32'h0, 32'h0, rd, flt);
    check_eq("sh_no_side_effect", 64'(rd), 64'h55667788);
    single(1'b0, 3'd3, 32'h0, 32'h0, rd, flt);
    check_eq("f3_011_fault", 64'(flt), 64'd1);
    single(1'b0, 3'd2, DEPTH * 4, 32'h0, rd, flt);
    check_eq("range_fault", 64'(flt), 64'd1);
    single(1'b1, 3'd4, 32'h0, 32'h0, rd, flt);
    check_eq("sbu_fault", 64'(flt), 64'd1);

    single(1'b1, 3'd2, 32'h20, 32'h12345678, rd, flt);
    cnt0 = rsp_cnt;
    drive(1'b0, 3'd2, 32'h20, 32'h0);
    idle_bus();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("dropped_rsp", 64'(rsp_cnt), 64'(cnt0));
    wait_ready();
    single(1'b0, 3'd2, 32'h20, 32'h0, rd, flt);
    check_eq("reclear_20", 64'(rd), 64'h0);
    single(1'b0, 3'd2, 32'h8, 32'h0, rd, flt);
    check_eq("reclear_08", 64'(rd), 64'h0);

    for (int k = 0; k < 64; k++) begin
      f3   = f3tab[$urandom_range(0, 4)];
      we   = 1'($urandom_range(0, 1));
      if (we) f3[2] = 1'b0;
      w    = $urandom_range(0, DEPTH - 1);
      lane = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) lane[0] = 1'b0;
      if (f3[1:0] == 2'b10) lane = 2'b00;
      drive(we, f3, (w << 2) | 32'(lane), $urandom());
    end
    idle_bus();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
